// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// Each accepted operation takes one EXEC cycle and is then held in RESP until its owner consumes it.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int MAX_OP = 5
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req0Valid,
   output logic              req0Ready,
   input  logic [DATA_W-1:0] req0In1,
   input  logic [DATA_W-1:0] req0In2,
   input  logic [OP_W-1:0]   req0Op,

   input  logic              req1Valid,
   output logic              req1Ready,
   input  logic [DATA_W-1:0] req1In1,
   input  logic [DATA_W-1:0] req1In2,
   input  logic [OP_W-1:0]   req1Op,

   output logic              resp0Valid,
   input  logic              resp0Ready,
   output logic              resp1Valid,
   input  logic              resp1Ready,
   output logic [DATA_W-1:0] respOut,
   output logic              respZero,
   output logic              respErr,

   output logic [DATA_W-1:0] aluIn1,
   output logic [DATA_W-1:0] aluIn2,
   output logic [OP_W-1:0]   aluOP,
   input  logic [DATA_W-1:0] aluOut,
   input  logic              aluZero
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t state;
   logic   last_grant;
   logic   owner;
   logic   grant0;
   logic   grant1;
   logic   illegal;
   logic   owner_ready;

   // last_grant holds the id of the most recently accepted requester; the other one wins a tie.
   always_comb begin
      grant0 = req0Valid && (!req1Valid || last_grant);
      grant1 = req1Valid && (!req0Valid || !last_grant);
   end

   assign req0Ready   = (state == IDLE) && !rst && grant0;
   assign req1Ready   = (state == IDLE) && !rst && grant1;
   assign resp0Valid  = (state == RESP) && !owner;
   assign resp1Valid  = (state == RESP) && owner;
   assign owner_ready = owner ? resp1Ready : resp0Ready;
   assign illegal     = aluOP > OP_W'(MAX_OP);

   // The ALU is only sampled at the EXEC->RESP edge, so aluOut never reaches an output combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         aluIn1     <= '0;
         aluIn2     <= '0;
         aluOP      <= '0;
         respOut    <= '0;
         respZero   <= 1'b0;
         respErr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0Ready) begin
                  aluIn1     <= req0In1;
                  aluIn2     <= req0In2;
                  aluOP      <= req0Op;
                  owner      <= 1'b0;
                  last_grant <= 1'b0;
                  state      <= EXEC;
               end else if (req1Ready) begin
                  aluIn1     <= req1In1;
                  aluIn2     <= req1In2;
                  aluOP      <= req1Op;
                  owner      <= 1'b1;
                  last_grant <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (illegal) begin
                  respOut  <= '0;
                  respZero <= 1'b0;
                  respErr  <= 1'b1;
               end else begin
                  respOut  <= aluOut;
                  respZero <= aluZero;
                  respErr  <= 1'b0;
               end
               state <= RESP;
            end
            RESP: begin
               if (owner_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Only one requester may ever be offered acceptance or a result at a time.
   assert property (@(posedge clk) disable iff (rst) !(req0Ready && req1Ready));
   assert property (@(posedge clk) disable iff (rst) !(resp0Valid && resp1Valid));

endmodule
